key_rom_loader: RTL and testbench



---
 rtl/key_rom_loader.sv | 181 ++++++++++++++++++
 tb/tb_key_rom_loader.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_rom_loader.sv
// Fetches a variable-length RC4 key from a synchronous ROM into a packed byte array.
// Supports a run-time base address, configurable ROM read latency and optional byte reversal.
module key_rom_loader #(
    parameter int KEY_LENGTH  = 32,
    parameter int ROM_LENGTH  = 5,
    parameter int ROM_WIDTH   = 8,
    parameter int ROM_LATENCY = 1
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 start,
    input  logic [ROM_LENGTH-1:0]                base_addr,
    input  logic [$clog2(KEY_LENGTH+1)-1:0]      key_len,
    input  logic                                 reverse,
    input  logic [ROM_WIDTH-1:0]                 rom_out,
    output logic [ROM_LENGTH-1:0]                address,
    output logic [KEY_LENGTH-1:0][ROM_WIDTH-1:0] key_arr,
    output logic                                 finished,
    output logic                                 error,
    output logic                                 busy,
    output logic [2:0]                           state_tap,
    output logic [ROM_WIDTH-1:0]                 out_tap
);

    localparam int LEN_W  = $clog2(KEY_LENGTH + 1);
    localparam int IDX_W  = (KEY_LENGTH > 1) ? $clog2(KEY_LENGTH) : 1;
    localparam int SUM_W  = ((ROM_LENGTH > LEN_W) ? ROM_LENGTH : LEN_W) + 1;
    localparam int WAIT_W = 2;
    localparam logic [SUM_W-1:0] ROM_MAX = SUM_W'((64'd1 << ROM_LENGTH) - 64'd1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_DONE    = 3'd4,
        ST_ERR     = 3'd5
    } state_t;

    state_t                              state_r;
    state_t                              next_state_s;
    logic [LEN_W-1:0]                    idx_r;
    logic [LEN_W-1:0]                    idx_s;
    logic [WAIT_W-1:0]                   wait_r;
    logic [WAIT_W-1:0]                   wait_s;
    logic [ROM_LENGTH-1:0]               base_r;
    logic [LEN_W-1:0]                    len_r;
    logic                                rev_r;
    logic [ROM_LENGTH-1:0]               address_r;
    logic [ROM_LENGTH-1:0]               address_s;
    logic [KEY_LENGTH-1:0][ROM_WIDTH-1:0] key_r;
    logic [ROM_WIDTH-1:0]                out_tap_r;
    logic                                finished_r;
    logic                                error_r;
    logic                                busy_r;
    logic [2:0]                          state_tap_r;
    logic [SUM_W-1:0]                    end_addr_s;
    logic                                range_err_s;
    logic                                accept_s;
    logic [IDX_W-1:0]                    slot_s;

    // Range check of the requested window, done on the raw inputs at accept time.
    always_comb begin
        end_addr_s  = SUM_W'(base_addr) + SUM_W'(key_len) - SUM_W'(1);
        range_err_s = (key_len == {LEN_W{1'b0}}) ||
                      (key_len > LEN_W'(KEY_LENGTH)) ||
                      (end_addr_s > ROM_MAX);
        accept_s    = (state_r == ST_IDLE) && start;
    end

    // Destination entry for the byte being captured; reversal mirrors around key_len-1.
    always_comb begin
        if (rev_r) begin
            slot_s = IDX_W'(len_r - LEN_W'(1) - idx_r);
        end else begin
            slot_s = IDX_W'(idx_r);
        end
    end

    // Next-state, byte index, wait counter and next ROM address.
    always_comb begin
        next_state_s = state_r;
        idx_s        = idx_r;
        wait_s       = wait_r;
        address_s    = address_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    idx_s = {LEN_W{1'b0}};
                    if (range_err_s) begin
                        next_state_s = ST_ERR;
                    end else begin
                        next_state_s = ST_ISSUE;
                        address_s    = base_addr;
                    end
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                next_state_s = ST_WAIT;
                wait_s       = {WAIT_W{1'b0}};
            end
            ST_WAIT: begin
                if (wait_r == WAIT_W'(ROM_LATENCY - 1)) begin
                    next_state_s = ST_CAPTURE;
                end else begin
                    wait_s = wait_r + WAIT_W'(1);
                end
            end
            ST_CAPTURE: begin
                if (idx_r == len_r - LEN_W'(1)) begin
                    next_state_s = ST_DONE;
                end else begin
                    idx_s        = idx_r + LEN_W'(1);
                    next_state_s = ST_ISSUE;
                    address_s    = base_r + ROM_LENGTH'(idx_r + LEN_W'(1));
                end
            end
            ST_DONE, ST_ERR: begin
                if (start) begin
                    next_state_s = state_r;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // State register, latched request, key assembly and registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            idx_r       <= {LEN_W{1'b0}};
            wait_r      <= {WAIT_W{1'b0}};
            base_r      <= {ROM_LENGTH{1'b0}};
            len_r       <= {LEN_W{1'b0}};
            rev_r       <= 1'b0;
            address_r   <= {ROM_LENGTH{1'b0}};
            key_r       <= {(KEY_LENGTH*ROM_WIDTH){1'b0}};
            out_tap_r   <= {ROM_WIDTH{1'b0}};
            finished_r  <= 1'b0;
            error_r     <= 1'b0;
            busy_r      <= 1'b0;
            state_tap_r <= 3'd0;
        end else begin
            state_r   <= next_state_s;
            idx_r     <= idx_s;
            wait_r    <= wait_s;
            address_r <= address_s;
            if (accept_s) begin
                base_r <= base_addr;
                len_r  <= key_len;
                rev_r  <= reverse;
                key_r  <= {(KEY_LENGTH*ROM_WIDTH){1'b0}};
            end
            if (state_r == ST_CAPTURE) begin
                key_r[slot_s] <= rom_out;
                out_tap_r     <= rom_out;
            end
            finished_r  <= (next_state_s == ST_DONE);
            error_r     <= (next_state_s == ST_ERR);
            busy_r      <= (next_state_s == ST_ISSUE) ||
                           (next_state_s == ST_WAIT)  ||
                           (next_state_s == ST_CAPTURE);
            state_tap_r <= next_state_s;
        end
    end

    assign address   = address_r;
    assign key_arr   = key_r;
    assign finished  = finished_r;
    assign error     = error_r;
    assign busy      = busy_r;
    assign state_tap = state_tap_r;
    assign out_tap   = out_tap_r;

endmodule

// File: tb/tb_key_rom_loader.sv
// Directed bench for key_rom_loader: two instances (ROM latency 1 and 3) share the request
// inputs, each fed by its own ROM model returning address ^ 8'hA5.
module tb_key_rom_loader;

    logic             clk;
    logic             reset;
    logic             start;
    logic [4:0]       base_addr;
    logic [5:0]       key_len;
    logic             reverse;

    logic [7:0]       rom_out_a;
    logic [4:0]       address_a;
    logic [31:0][7:0] key_arr_a;
    logic             finished_a;
    logic             error_a;
    logic             busy_a;
    logic [2:0]       state_tap_a;
    logic [7:0]       out_tap_a;

    logic [7:0]       rom_out_b;
    logic [4:0]       address_b;
    logic [31:0][7:0] key_arr_b;
    logic             finished_b;
    logic             error_b;
    logic             busy_b;
    logic [2:0]       state_tap_b;
    logic [7:0]       out_tap_b;
    logic [7:0]       pipe_b1;
    logic [7:0]       pipe_b2;

    int checks;
    int errors;
    int cyc;
    int fin_a_at;
    int fin_b_at;
    int fin_a_cnt;
    int fin_b_cnt;
    int busy_seen_a;
    int busy_after_a;
    int busy_after_b;

    key_rom_loader #(.KEY_LENGTH(32), .ROM_LENGTH(5), .ROM_WIDTH(8), .ROM_LATENCY(1)) dut_a (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .key_len(key_len),
        .reverse(reverse), .rom_out(rom_out_a), .address(address_a), .key_arr(key_arr_a),
        .finished(finished_a), .error(error_a), .busy(busy_a), .state_tap(state_tap_a),
        .out_tap(out_tap_a)
    );

    key_rom_loader #(.KEY_LENGTH(32), .ROM_LENGTH(5), .ROM_WIDTH(8), .ROM_LATENCY(3)) dut_b (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .key_len(key_len),
        .reverse(reverse), .rom_out(rom_out_b), .address(address_b), .key_arr(key_arr_b),
        .finished(finished_b), .error(error_b), .busy(busy_b), .state_tap(state_tap_b),
        .out_tap(out_tap_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] rom_val(input logic [4:0] a);
        return {3'b000, a} ^ 8'hA5;
    endfunction

    function automatic logic [255:0] exp_key(input int b, input int l, input bit r);
        logic [255:0] k;
        int slot;
        k = '0;
        for (int i = 0; i < l; i++) begin
            slot = r ? (l - 1 - i) : i;
            k[slot*8 +: 8] = rom_val(5'(b + i));
        end
        return k;
    endfunction

    // One-cycle and three-cycle synchronous ROM models
    always @(posedge clk) begin
        rom_out_a <= rom_val(address_a);
        pipe_b1   <= rom_val(address_b);
        pipe_b2   <= pipe_b1;
        rom_out_b <= pipe_b2;
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        cyc          = 0;
        fin_a_at     = -1;
        fin_b_at     = -1;
        fin_a_cnt    = 0;
        fin_b_cnt    = 0;
        busy_seen_a  = 0;
        busy_after_a = 0;
        busy_after_b = 0;
    endtask

    // Presents a request and returns just after the accept edge
    task automatic do_accept(input int b, input int l, input bit r);
        @(negedge clk);
        base_addr = 5'(b);
        key_len   = 6'(l);
        reverse   = r;
        start     = 1'b1;
        @(posedge clk);
        #1;
        clear_stats();
    endtask

    task automatic run_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (finished_a) begin
                if (fin_a_at < 0) fin_a_at = cyc;
                fin_a_cnt++;
            end
            if (finished_b) begin
                if (fin_b_at < 0) fin_b_at = cyc;
                fin_b_cnt++;
            end
            if (busy_a) busy_seen_a++;
            if (busy_a && fin_a_at >= 0) busy_after_a++;
            if (busy_b && fin_b_at >= 0) busy_after_b++;
        end
    endtask

    task automatic drop_start();
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        reset     = 1'b1;
        start     = 1'b0;
        base_addr = 5'd0;
        key_len   = 6'd0;
        reverse   = 1'b0;
        clear_stats();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("rst_state", 256'(state_tap_a), 256'(3'd0));
        check("rst_addr", 256'(address_a), 256'(5'd0));
        check("rst_key", 256'(key_arr_a), 256'(0));
        check("rst_flags", 256'({finished_a, error_a, busy_a}), 256'(3'b000));
        check("rst_out_tap", 256'(out_tap_a), 256'(8'd0));

        // zero-length request
        do_accept(0, 0, 0);
        check("err0_error", 256'({error_a, error_b}), 256'(2'b11));
        check("err0_state", 256'(state_tap_a), 256'(3'd5));
        run_cycles(3);
        check("err0_hold", 256'(error_a), 256'(1'b1));
        check("err0_busy", 256'(busy_seen_a), 256'(0));
        check("err0_addr", 256'(address_a), 256'(5'd0));
        drop_start();
        run_cycles(1);
        check("err0_release", 256'({error_a, state_tap_a}), 256'({1'b0, 3'd0}));

        // window past the top of the ROM: 30+3-1 = 32
        do_accept(30, 3, 0);
        check("err_range", 256'(error_a), 256'(1'b1));
        run_cycles(3);
        check("err_range_busy", 256'(busy_seen_a), 256'(0));
        check("err_range_addr", 256'(address_a), 256'(5'd0));
        drop_start();
        run_cycles(1);

        // longer than KEY_LENGTH
        do_accept(0, 33, 0);
        check("err_len33", 256'(error_a), 256'(1'b1));
        drop_start();
        run_cycles(1);

        // nominal load, start held high through DONE
        do_accept(0, 3, 0);
        run_cycles(20);
        check("nom_fin_a", 256'(fin_a_at), 256'(9));
        check("nom_fin_b", 256'(fin_b_at), 256'(15));
        check("nom_key_a", 256'(key_arr_a), exp_key(0, 3, 0));
        check("nom_key_b", 256'(key_arr_b), exp_key(0, 3, 0));
        check("nom_hold", 256'({finished_a, state_tap_a}), 256'({1'b1, 3'd4}));
        check("nom_no_retrig", 256'(busy_after_a), 256'(0));
        check("nom_out_tap", 256'(out_tap_a), 256'(8'hA7));
        drop_start();
        run_cycles(1);
        check("nom_release", 256'({finished_a, state_tap_a}), 256'({1'b0, 3'd0}));
        check("nom_key_kept", 256'(key_arr_a), exp_key(0, 3, 0));

        // reversal with offset
        do_accept(5, 4, 1);
        run_cycles(25);
        check("rev_fin_a", 256'(fin_a_at), 256'(12));
        check("rev_key_a", 256'(key_arr_a), exp_key(5, 4, 1));
        check("rev_key3", 256'(key_arr_a[3]), 256'(8'hA0));
        check("rev_key0", 256'(key_arr_a[0]), 256'(8'hAD));
        check("rev_key_b", 256'(key_arr_b), exp_key(5, 4, 1));
        check("rev_out_tap", 256'(out_tap_b), 256'(8'hAD));
        drop_start();
        run_cycles(1);

        // top-of-ROM window that just fits: 29..31
        do_accept(29, 3, 0);
        check("edge_no_err", 256'({error_a, state_tap_a}), 256'({1'b0, 3'd1}));
        run_cycles(20);
        check("edge_key_a", 256'(key_arr_a), exp_key(29, 3, 0));
        drop_start();
        run_cycles(1);

        // start dropped during byte 2 of a 4-byte load
        do_accept(0, 4, 0);
        run_cycles(7);
        drop_start();
        run_cycles(40);
        check("tog_fin_cnt_a", 256'(fin_a_cnt), 256'(1));
        check("tog_fin_cnt_b", 256'(fin_b_cnt), 256'(1));
        check("tog_fin_at_b", 256'(fin_b_at), 256'(20));
        check("tog_idle", 256'({state_tap_a, state_tap_b}), 256'({3'd0, 3'd0}));
        check("tog_no_reload", 256'(busy_after_a + busy_after_b), 256'(0));
        check("tog_key_a", 256'(key_arr_a), exp_key(0, 4, 0));

        // full-length load, both latencies
        do_accept(0, 32, 0);
        run_cycles(170);
        check("full_fin_a", 256'(fin_a_at), 256'(96));
        check("full_fin_b", 256'(fin_b_at), 256'(160));
        check("full_key_a", 256'(key_arr_a), exp_key(0, 32, 0));
        check("full_key_b", 256'(key_arr_b), exp_key(0, 32, 0));
        drop_start();
        run_cycles(1);

        // reset during WAIT of byte 10
        do_accept(0, 32, 0);
        run_cycles(31);
        check("mid_wait_state", 256'(state_tap_a), 256'(3'd2));
        check("mid_wait_addr", 256'(address_a), 256'(5'd10));
        @(negedge clk);
        reset = 1'b1;
        start = 1'b0;
        @(posedge clk);
        #1;
        check("mid_rst_state", 256'({state_tap_a, state_tap_b}), 256'({3'd0, 3'd0}));
        check("mid_rst_key", 256'(key_arr_a), 256'(0));
        check("mid_rst_flags", 256'({finished_a, busy_a, address_a}), 256'(0));
        @(negedge clk);
        reset = 1'b0;
        do_accept(2, 5, 1);
        run_cycles(30);
        check("post_rst_fin_a", 256'(fin_a_at), 256'(15));
        check("post_rst_key_a", 256'(key_arr_a), exp_key(2, 5, 1));
        check("post_rst_key_b", 256'(key_arr_b), exp_key(2, 5, 1));
        drop_start();
        run_cycles(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
